// File: rtl/audio_serializer_if.sv
// Sample-source / codec-pin bundle of the I2S transmit serializer.
// The master drives the run request and sample; the serializer (slave) drives the clocks and data.
interface audio_serializer_if;
    logic        enable;
    logic [15:0] sample;
    logic        bclk;
    logic        lrck;
    logic        lrck_last;
    logic        dacdat;
    logic        sample_strobe;
    logic        busy;

    modport master (
        output enable, sample,
        input  bclk, lrck, lrck_last, dacdat, sample_strobe, busy
    );

    modport slave (
        input  enable, sample,
        output bclk, lrck, lrck_last, dacdat, sample_strobe, busy
    );
endinterface

// File: rtl/audio_serializer.sv
// I2S transmitter: derives bclk/lrck from the system clock and shifts out a 16-bit mono
// sample MSB first in both slots, with the one-bclk I2S data delay.
module audio_serializer #(
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 16
) (
    input  logic                clock,
    input  logic                reset,
    audio_serializer_if.slave   bus
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DATA_END = BW'(16);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            bclk_q, bclk_d;
    logic            lrck_q, lrck_d;
    logic            lrck_last_q, lrck_last_d;
    logic            dacdat_q, dacdat_d;
    logic            strobe_q, strobe_d;
    logic            busy_q, busy_d;
    logic [15:0]     shadow_q, shadow_d;
    logic            last_lsb_q, last_lsb_d;

    logic            fall;
    logic            frame_end;
    logic [BW-1:0]   bit_next;
    logic [BW-1:0]   pos;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        lrck_last_d = lrck_q;
        dacdat_d    = dacdat_q;
        strobe_d    = 1'b0;
        shadow_d    = shadow_q;
        last_lsb_d  = last_lsb_q;

        fall      = (state_q != IDLE) && (div_cnt_q == DIV_LAST) && bclk_q;
        bit_next  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
        frame_end = fall && (bit_cnt_q == BIT_LAST);
        pos       = (bit_next >= SLOT_LEN) ? bit_next - SLOT_LEN : bit_next;

        unique case (state_q)
            IDLE:    if (bus.enable) state_d = RUN;
            RUN:     if (!bus.enable) state_d = STOP;
            STOP: begin
                if (bus.enable) state_d = RUN;
                if (frame_end)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
            if (div_cnt_q == DIV_LAST) bclk_d = ~bclk_q;
        end

        if (fall) begin
            bit_cnt_d = bit_next;
            lrck_d    = (bit_next >= SLOT_LEN);
            if (bit_next == SLOT_LEN) last_lsb_d = shadow_q[0];
            if (frame_end && state_q == RUN) begin
                last_lsb_d = shadow_q[0];
                shadow_d   = bus.sample;
                strobe_d   = 1'b1;
            end
            // Slot position 0 carries the previous slot's LSB (I2S one-bclk delay).
            if (pos == '0)            dacdat_d = last_lsb_d;
            else if (pos <= DATA_END) dacdat_d = shadow_q[4'(5'd16 - 5'(pos))];
            else                      dacdat_d = 1'b0;
        end

        // Staying in or returning to IDLE overrides any falling-event update.
        if (state_d == IDLE) begin
            div_cnt_d  = '0;
            bit_cnt_d  = BIT_LAST;
            bclk_d     = 1'b0;
            lrck_d     = 1'b1;
            dacdat_d   = 1'b0;
            strobe_d   = 1'b0;
            shadow_d   = '0;
            last_lsb_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= BIT_LAST;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b1;
            lrck_last_q <= 1'b1;
            dacdat_q    <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            shadow_q    <= '0;
            last_lsb_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            lrck_last_q <= lrck_last_d;
            dacdat_q    <= dacdat_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            shadow_q    <= shadow_d;
            last_lsb_q  <= last_lsb_d;
        end
    end

    assign bus.bclk          = bclk_q;
    assign bus.lrck          = lrck_q;
    assign bus.lrck_last     = lrck_last_q;
    assign bus.dacdat        = dacdat_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_audio_serializer.sv
// Bench for audio_serializer: every clock the outputs are compared with a timeline model
// that derives bclk, lrck, strobe and the data bit from the elapsed run time.
module tb_audio_serializer;
    localparam int D     = 2;
    localparam int S     = 20;
    localparam int FRAME = 2 * D * 2 * S;

    logic clock;
    logic rst_n;
    audio_serializer_if bus ();

    audio_serializer #(.BCLK_DIV(D), .SLOT_BITS(S)) dut (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    int          t        = 0;
    bit          active   = 1'b0;
    bit          stopping = 1'b0;
    logic [15:0] frm [0:63];
    logic        e_bclk, e_lrck = 1'b1, e_ll, e_dac, e_stb, e_busy;

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0d active=%0d: observed %b expected %b", tag, t, active, got, exp);
        end
    endtask

    // Advance one clock and compare against the timeline model.
    task automatic step();
        logic        en, rs;
        logic [15:0] smp;
        bit          fe;
        int          n, f, j, p;
        en  = bus.enable;
        rs  = rst_n;
        smp = bus.sample;
        @(posedge clock);
        #1;
        e_ll   = rs ? e_lrck : 1'b1;
        e_bclk = 1'b0; e_lrck = 1'b1; e_dac = 1'b0; e_stb = 1'b0; e_busy = 1'b0;
        if (!rs) begin
            active = 1'b0;
        end else if (!active) begin
            if (en) begin
                active = 1'b1; t = 0; stopping = 1'b0; e_busy = 1'b1;
            end
        end else begin
            t++;
            fe = (t >= 2 * D) && ((t - 2 * D) % FRAME == 0);
            if (fe && stopping) begin
                active = 1'b0;
            end else begin
                stopping = !en;
                e_busy   = 1'b1;
                e_bclk   = ((t / D) % 2) == 1;
                if (t >= 2 * D) begin
                    n = t / (2 * D) - 1;
                    f = n / (2 * S);
                    j = n % (2 * S);
                    p = j % S;
                    if (fe) frm[f] = smp;
                    e_lrck = (j >= S);
                    e_stb  = fe;
                    if (p == 0)       e_dac = (j == 0) ? ((f == 0) ? 1'b0 : frm[f-1][0]) : frm[f][0];
                    else if (p <= 16) e_dac = frm[f][16-p];
                end
            end
        end
        chk("bclk",          bus.bclk,          e_bclk);
        chk("lrck",          bus.lrck,          e_lrck);
        chk("lrck_last",     bus.lrck_last,     e_ll);
        chk("dacdat",        bus.dacdat,        e_dac);
        chk("sample_strobe", bus.sample_strobe, e_stb);
        chk("busy",          bus.busy,          e_busy);
    endtask

    task automatic rstep();
        bus.sample = 16'($urandom);
        step();
    endtask

    // Run with random samples until the model sits at a given offset inside a frame.
    task automatic run_to(input int off);
        for (int i = 0; i < 2 * FRAME; i++) begin
            rstep();
            if (active && t >= 2 * D && ((t - 2 * D) % FRAME) == off) break;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        bus.sample = 16'h0000;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Fixed sample, then the source swaps it one clock after the strobe.
        bus.enable = 1'b1;
        bus.sample = 16'hA5C3;
        for (int i = 0; i < 4 * D + 4; i++) begin
            step();
            if (e_stb) break;
        end
        bus.sample = 16'h0001;
        repeat (2 * FRAME) step();

        // Random samples changing every clock; only frame-end values may be sent.
        repeat (2 * FRAME) rstep();

        // Stop in the middle of the right slot; frame completes, then idle.
        run_to(2 * D * (S + 5));
        bus.enable = 1'b0;
        for (int i = 0; i < 2 * FRAME && active; i++) rstep();
        repeat (4) rstep();

        // Restart, then reset mid left slot with enable still high.
        bus.enable = 1'b1;
        rstep();
        run_to(2 * D * 7);
        rstep();
        rst_n = 1'b0;
        rstep();
        rst_n = 1'b1;
        repeat (FRAME + 10) rstep();

        // Brief enable drop inside the left slot: transmission must continue seamlessly.
        run_to(2 * D * 6);
        bus.enable = 1'b0;
        repeat (7) rstep();
        bus.enable = 1'b1;
        repeat (2 * FRAME) rstep();

        bus.enable = 1'b0;
        for (int i = 0; i < 2 * FRAME && active; i++) rstep();
        repeat (3) rstep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
